tensor_core_driver: RTL and testbench

- Command-side initiator for `small_tensor_core`.
- Accepts an opcode command and a byte stream of operand elements, then fills the core's two 3x3 input register files.
- Pulses the core's write-enable, then its start, waits for completion, captures the 3x3 result, and streams the result back out over a valid/ready port.
- Sits between the host/bus interface and the tensor core, and is the only block that drives the core's control inputs.

---
 rtl/tensor_core_driver.sv | 203 ++++++++++++++++++++
 tb/tb_tensor_core_driver.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_core_driver.sv
// tensor_core_driver
// Command-side initiator for small_tensor_core. Accepts an opcode and an
// operand byte stream, loads the core's two 3x3 operand register files,
// pulses write-enable and start, waits a fixed number of cycles, captures
// the 3x3 result and streams it out over a valid/ready port.
module tensor_core_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 10
) (
  input  logic                                tensor_core_clock,
  input  logic                                reset_n_in,
  input  logic                                abort_in,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [2:0]                          cmd_opcode,
  output logic                                cmd_error,
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                done,
  output logic [0:2][0:2][DATA_WIDTH-1:0]     tensor_core_input1,
  output logic [0:2][0:2][DATA_WIDTH-1:0]     tensor_core_input2,
  output logic                                tensor_core_register_file_write_enable,
  output logic                                should_start_tensor_core,
  output logic [2:0]                          operation_select,
  input  logic [0:2][0:2][DATA_WIDTH-1:0]     tensor_core_output
);

  localparam logic [2:0] OP_MATMUL = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_RELU   = 3'b010;

  localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                 state;
  logic [4:0]             idx;
  logic [CNT_W-1:0]       wait_cnt;

  // Flat row-major storage: element k lives at row k/3, column k%3.
  logic [DATA_WIDTH-1:0]  operand_a [9];
  logic [DATA_WIDTH-1:0]  operand_b [9];
  logic [DATA_WIDTH-1:0]  result    [9];

  logic opcode_legal;
  logic cmd_fire;
  logic load_fire;
  logic load_last;
  logic drain_fire;
  logic capture;

  // Abort wins over every handshake in the same cycle.
  assign opcode_legal = (cmd_opcode == OP_MATMUL) || (cmd_opcode == OP_ADD) ||
                        (cmd_opcode == OP_RELU);
  assign cmd_fire     = cmd_valid && cmd_ready && !abort_in;
  assign load_fire    = data_in_valid && data_in_ready && !abort_in;
  assign drain_fire   = out_valid && out_ready && !abort_in;
  assign capture      = (state == S_WAIT) && (wait_cnt == '0) && !abort_in;

  // relu only needs operand A, so its load stops after nine elements.
  assign load_last    = (operation_select == OP_RELU) ? (idx == 5'd8) : (idx == 5'd17);

  // Result element presented on the output port follows the drain index.
  assign out_data     = (idx < 5'd9) ? result[idx[3:0]] : '0;

  // Control FSM; every handshake/pulse output is a register set on the transition.
  always_ff @(posedge tensor_core_clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state                                  <= S_IDLE;
      idx                                    <= '0;
      wait_cnt                               <= '0;
      operation_select                       <= '0;
      cmd_ready                              <= 1'b0;
      cmd_error                              <= 1'b0;
      data_in_ready                          <= 1'b0;
      out_valid                              <= 1'b0;
      done                                   <= 1'b0;
      tensor_core_register_file_write_enable <= 1'b0;
      should_start_tensor_core               <= 1'b0;
    end else begin
      cmd_error                              <= 1'b0;
      done                                   <= 1'b0;
      tensor_core_register_file_write_enable <= 1'b0;
      should_start_tensor_core               <= 1'b0;

      if (abort_in) begin
        state         <= S_IDLE;
        cmd_ready     <= 1'b1;
        data_in_ready <= 1'b0;
        out_valid     <= 1'b0;
        idx           <= '0;
        wait_cnt      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_fire) begin
              if (opcode_legal) begin
                operation_select <= cmd_opcode;
                idx              <= '0;
                cmd_ready        <= 1'b0;
                data_in_ready    <= 1'b1;
                state            <= S_LOAD;
              end else begin
                cmd_error <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (load_fire) begin
              if (load_last) begin
                idx                                    <= '0;
                data_in_ready                          <= 1'b0;
                tensor_core_register_file_write_enable <= 1'b1;
                state                                  <= S_WRITE;
              end else begin
                idx <= idx + 5'd1;
              end
            end
          end
          S_WRITE: begin
            should_start_tensor_core <= 1'b1;
            state                    <= S_START;
          end
          S_START: begin
            wait_cnt <= WAIT_RELOAD;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == '0) begin
              idx       <= '0;
              out_valid <= 1'b1;
              state     <= S_DRAIN;
            end else begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end
          end
          S_DRAIN: begin
            if (drain_fire) begin
              if (idx == 5'd8) begin
                idx       <= '0;
                out_valid <= 1'b0;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
              end else begin
                idx <= idx + 5'd1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Operand loading and result capture; operands persist across commands and aborts.
  always_ff @(posedge tensor_core_clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int k = 0; k < 9; k++) begin
        operand_a[k] <= '0;
        operand_b[k] <= '0;
        result[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (load_fire && (idx == 5'(k))) begin
          operand_a[k] <= data_in;
        end
        if (load_fire && (idx == 5'(k + 9))) begin
          operand_b[k] <= data_in;
        end
        if (capture) begin
          result[k] <= tensor_core_output[k / 3][k % 3];
        end
      end
    end
  end

  // Present the flat operand storage to the core as 3x3 matrices.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_operand_map
      assign tensor_core_input1[gi / 3][gi % 3] = operand_a[gi];
      assign tensor_core_input2[gi / 3][gi % 3] = operand_b[gi];
    end
  endgenerate

endmodule

// File: tb/tb_tensor_core_driver.sv
// tb_tensor_core_driver
// Self-checking bench: a behavioural small_tensor_core model answers the
// driver, directed and randomized commands are run, and every result beat,
// pulse count, latency and boundary behaviour is compared against values the
// bench derives itself.
`timescale 1ns/1ps
module tb_tensor_core_driver;

  localparam int W  = 8;
  localparam int WC = 10;
  localparam logic [2:0] OP_MATMUL = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_RELU   = 3'b010;

  // Flat row-major 3x3 matrix: element k = row k/3, column k%3.
  typedef logic [8:0][W-1:0] mat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n = 1'b0;
  logic                      abort = 1'b0;
  logic                      cmd_valid = 1'b0;
  logic                      cmd_ready;
  logic [2:0]                cmd_opcode = 3'b000;
  logic                      cmd_error;
  logic                      din_valid = 1'b0;
  logic                      din_ready;
  logic [W-1:0]              din = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [W-1:0]              out_data;
  logic                      done;
  logic [0:2][0:2][W-1:0]    in1;
  logic [0:2][0:2][W-1:0]    in2;
  logic                      we;
  logic                      start;
  logic [2:0]                op_sel;
  logic [0:2][0:2][W-1:0]    core_bus;

  int passed = 0;
  int total  = 0;
  int cyc = 0;
  int we_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  mat_t exp_a = '0;
  mat_t exp_b = '0;
  logic [2:0] last_op = 3'b000;

  tensor_core_driver #(.DATA_WIDTH(W), .WAIT_CYCLES(WC)) dut (
    .tensor_core_clock                      (clk),
    .reset_n_in                             (rst_n),
    .abort_in                               (abort),
    .cmd_valid                              (cmd_valid),
    .cmd_ready                              (cmd_ready),
    .cmd_opcode                             (cmd_opcode),
    .cmd_error                              (cmd_error),
    .data_in_valid                          (din_valid),
    .data_in_ready                          (din_ready),
    .data_in                                (din),
    .out_valid                              (out_valid),
    .out_ready                              (out_ready),
    .out_data                               (out_data),
    .done                                   (done),
    .tensor_core_input1                     (in1),
    .tensor_core_input2                     (in2),
    .tensor_core_register_file_write_enable (we),
    .should_start_tensor_core               (start),
    .operation_select                       (op_sel),
    .tensor_core_output                     (core_bus)
  );

  // Behavioural operation: signed arithmetic, result truncated to W bits.
  function automatic mat_t model(input logic [2:0] op, input mat_t a, input mat_t b);
    mat_t r;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (op == OP_MATMUL) begin
          s = 0;
          for (int k = 0; k < 3; k++) s = s + $signed(a[i*3+k]) * $signed(b[k*3+j]);
          r[i*3+j] = s[W-1:0];
        end else if (op == OP_ADD) begin
          r[i*3+j] = a[i*3+j] + b[i*3+j];
        end else begin
          r[i*3+j] = a[i*3+j][W-1] ? '0 : a[i*3+j];
        end
      end
    end
    return r;
  endfunction

  function automatic mat_t to_mat(input logic [0:2][0:2][W-1:0] m);
    mat_t r;
    for (int k = 0; k < 9; k++) r[k] = m[k/3][k%3];
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    for (int k = 0; k < 9; k++) r[k] = W'($urandom);
    return r;
  endfunction

  // Core model: latch operands on write-enable, compute on start.
  mat_t core_a = '0;
  mat_t core_b = '0;
  mat_t core_res = '0;
  logic [2:0] core_op = 3'b000;
  always @(posedge clk) begin
    if (we) begin
      core_a  <= to_mat(in1);
      core_b  <= to_mat(in2);
      core_op <= op_sel;
    end
    if (start) core_res <= model(core_op, core_a, core_b);
  end
  always_comb begin
    core_bus = '0;
    for (int k = 0; k < 9; k++) core_bus[k/3][k%3] = core_res[k];
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (we)    we_cnt    <= we_cnt + 1;
    if (start) start_cnt <= start_cnt + 1;
    if (done)  done_cnt  <= done_cnt + 1;
  end

  task automatic send_cmd(input logic [2:0] op);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
    else passed++;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic load_ops(input logic [2:0] op, input mat_t a, input mat_t b,
                          input int in_mode, output int hs_cyc);
    int n, i, guard;
    n = (op == OP_RELU) ? 9 : 18;
    i = 0;
    guard = 0;
    hs_cyc = 0;
    while (i < n && guard < 500) begin
      @(negedge clk);
      din_valid = (in_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i < 9) din = a[i];
      else       din = b[i-9];
      if (din_valid && din_ready) begin
        hs_cyc = cyc;
        i++;
      end
      guard++;
    end
    total++;
    if (i != n) $display("FAIL load_count got=%0d exp=%0d", i, n);
    else passed++;
    @(negedge clk);
    din_valid = 1'b0;
    total++;
    if (din_ready !== 1'b0) $display("FAIL load_ready_drop got=%b exp=0", din_ready);
    else passed++;
  endtask

  task automatic wait_out_valid(input int hs_cyc);
    int guard;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (cyc - hs_cyc != WC + 3)
      $display("FAIL latency got=%0d exp=%0d", cyc - hs_cyc, WC + 3);
    else passed++;
  endtask

  // Full command: load, wait, drain with the chosen back-pressure, then check.
  task automatic run_op(input string name, input logic [2:0] op, input mat_t a, input mat_t b,
                        input mat_t exp_r, input int in_mode, input int out_mode,
                        input bit hold_cmd);
    int hs_cyc, beats, guard, phase, we0, st0, dn0;
    logic stalled;
    logic [W-1:0] held;
    mat_t b_after;
    b_after = (op == OP_RELU) ? exp_b : b;
    we0 = we_cnt;
    st0 = start_cnt;
    dn0 = done_cnt;
    send_cmd(op);
    load_ops(op, a, b, in_mode, hs_cyc);
    wait_out_valid(hs_cyc);
    if (hold_cmd) begin
      cmd_valid  = 1'b1;
      cmd_opcode = OP_RELU;
    end
    beats = 0;
    guard = 0;
    phase = 0;
    stalled = 1'b0;
    held = '0;
    while (beats < 9 && guard < 300) begin
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (phase % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held)
          $display("FAIL %s stall_hold beat=%0d got=%b/%h exp=1/%h", name, beats, out_valid, out_data, held);
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== exp_r[beats])
          $display("FAIL %s result beat=%0d got=%h exp=%h", name, beats, out_data, exp_r[beats]);
        else passed++;
        $display("%s beat %0d data=%h", name, beats, out_data);
        beats++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held = out_data;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    total++;
    if (beats != 9) $display("FAIL %s beat_count got=%0d exp=9", name, beats);
    else passed++;
    total++;
    if ({done, cmd_ready, out_valid} !== 3'b110)
      $display("FAIL %s end_flags done/ready/valid got=%b exp=110", name, {done, cmd_ready, out_valid});
    else passed++;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || done_cnt - dn0 != 1)
      $display("FAIL %s tail valid/done_pulses got=%b/%0d exp=0/1", name, out_valid, done_cnt - dn0);
    else passed++;
    total++;
    if (we_cnt - we0 != 1 || start_cnt - st0 != 1)
      $display("FAIL %s pulse_widths we/start got=%0d/%0d exp=1/1", name, we_cnt - we0, start_cnt - st0);
    else passed++;
    total++;
    if (op_sel !== op) $display("FAIL %s op_sel got=%b exp=%b", name, op_sel, op);
    else passed++;
    total++;
    if (to_mat(in1) !== a || to_mat(in2) !== b_after)
      $display("FAIL %s operands_hold got=%h/%h exp=%h/%h", name, to_mat(in1), to_mat(in2), a, b_after);
    else passed++;
    exp_a = a;
    exp_b = b_after;
    last_op = op;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({cmd_ready, din_ready, out_valid, done, we, start, cmd_error, op_sel, out_data} !== '0 ||
        in1 !== '0 || in2 !== '0)
      $display("FAIL reset_outputs got=%b%b%b%b%b%b%b op=%b exp=all0",
               cmd_ready, din_ready, out_valid, done, we, start, cmd_error, op_sel);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
    else passed++;
    $display("reset released, cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_matmul_identity();
    mat_t a, b, e;
    b = '0;
    for (int k = 0; k < 9; k++) begin
      a[k] = W'(k + 1);
      e[k] = W'(k + 1);
    end
    b[0] = 8'd1; b[4] = 8'd1; b[8] = 8'd1;
    run_op("matmul_identity", OP_MATMUL, a, b, e, 0, 0, 1'b0);
  endtask

  task automatic test_add_wrap();
    mat_t a, b, e;
    for (int k = 0; k < 9; k++) begin
      a[k] = 8'd100;
      b[k] = 8'd50;
      e[k] = 8'h96;
    end
    run_op("add_wrap", OP_ADD, a, b, e, 0, 0, 1'b0);
  endtask

  task automatic test_relu();
    mat_t a, e;
    a = {8'hF9, 8'h06, 8'h05, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h04, 8'hFD};
    e = {8'h00, 8'h06, 8'h05, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h04, 8'h00};
    run_op("relu", OP_RELU, a, rand_mat(), e, 1, 0, 1'b0);
  endtask

  task automatic test_illegal_opcode();
    send_cmd(3'b101);
    @(negedge clk);
    total++;
    if (cmd_error !== 1'b1 || din_ready !== 1'b0 || op_sel !== last_op)
      $display("FAIL illegal_pulse err/din_ready/op got=%b/%b/%b exp=1/0/%b", cmd_error, din_ready, op_sel, last_op);
    else passed++;
    @(negedge clk);
    total++;
    if (cmd_error !== 1'b0 || cmd_ready !== 1'b1 || din_ready !== 1'b0)
      $display("FAIL illegal_after err/cmd_ready/din_ready got=%b/%b/%b exp=0/1/0", cmd_error, cmd_ready, din_ready);
    else passed++;
    $display("illegal opcode 101 rejected");
    begin
      mat_t a, b;
      a = rand_mat();
      b = rand_mat();
      run_op("after_illegal", OP_ADD, a, b, model(OP_ADD, a, b), 1, 2, 1'b0);
    end
  endtask

  task automatic test_stall();
    mat_t a, b, e;
    for (int k = 0; k < 9; k++) begin
      a[k] = 8'd2;
      b[k] = 8'd3;
      e[k] = 8'd18;
    end
    run_op("stall", OP_MATMUL, a, b, e, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    mat_t a, b;
    logic [2:0] op;
    for (int t = 0; t < 8; t++) begin
      op = 3'($urandom_range(0, 2));
      a = rand_mat();
      b = rand_mat();
      run_op("random", op, a, b, model(op, a, op == OP_RELU ? exp_b : b), 1, 2, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    mat_t a, b;
    a = rand_mat();
    b = rand_mat();
    run_op("b2b_first", OP_MATMUL, a, b, model(OP_MATMUL, a, b), 0, 0, 1'b1);
    a = rand_mat();
    b = rand_mat();
    run_op("b2b_second", OP_ADD, a, b, model(OP_ADD, a, b), 0, 0, 1'b0);
  endtask

  task automatic test_abort_then_reset();
    mat_t a, b;
    int hs_cyc, dn0, we0, st0, guard;
    logic saw_valid;
    a = rand_mat();
    b = rand_mat();
    dn0 = done_cnt;
    send_cmd(OP_MATMUL);
    load_ops(OP_MATMUL, a, b, 0, hs_cyc);
    guard = 0;
    while (start !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({cmd_ready, out_valid, din_ready} !== 3'b100 || op_sel !== OP_MATMUL || to_mat(in1) !== a)
      $display("FAIL abort_state ready/valid/din_ready got=%b op=%b exp=100 op=000",
               {cmd_ready, out_valid, din_ready}, op_sel);
    else passed++;
    saw_valid = 1'b0;
    repeat (WC + 6) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid !== 1'b0 || done_cnt != dn0)
      $display("FAIL abort_quiet valid/done got=%b/%0d exp=0/0", saw_valid, done_cnt - dn0);
    else passed++;
    $display("abort in WAIT returned to IDLE");
    exp_a = a;
    exp_b = b;

    a = rand_mat();
    b = rand_mat();
    send_cmd(OP_ADD);
    load_ops(OP_ADD, a, b, 0, hs_cyc);
    wait_out_valid(hs_cyc);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    we0 = we_cnt;
    st0 = start_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, din_ready, out_valid, done, we, start, cmd_error, op_sel, out_data} !== '0 ||
        in1 !== '0 || in2 !== '0)
      $display("FAIL midreset_outputs got=%b%b%b%b%b%b%b op=%b exp=all0",
               cmd_ready, din_ready, out_valid, done, we, start, cmd_error, op_sel);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midreset_release ready/valid got=%b/%b exp=1/0", cmd_ready, out_valid);
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt != dn0 || we_cnt != we0 || start_cnt != st0)
      $display("FAIL midreset_no_pulses done/we/start got=%0d/%0d/%0d exp=0/0/0",
               done_cnt - dn0, we_cnt - we0, start_cnt - st0);
    else passed++;
    $display("reset during DRAIN recovered");
    exp_a = '0;
    exp_b = '0;
    last_op = 3'b000;
  endtask

  initial begin
    test_reset();
    test_matmul_identity();
    test_add_wrap();
    test_relu();
    test_illegal_opcode();
    test_stall();
    test_random();
    test_back_to_back();
    test_abort_then_reset();
    begin
      mat_t a, b;
      a = rand_mat();
      b = rand_mat();
      run_op("post_reset", OP_MATMUL, a, b, model(OP_MATMUL, a, b), 1, 2, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
